// File: rtl/ahb_sram_ws.sv
// AHB-Lite tightly coupled SRAM slave: configurable read/write wait states,
// byte-lane writes, two-cycle ERROR responses and read-after-write forwarding.
module ahb_sram_ws #(
  parameter int HADDR_WIDTH = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 64,
  parameter int RD_WAIT     = 0,
  parameter int WR_WAIT     = 0,
  parameter int USE_HWSTRB  = 0
) (
  input  logic                    hclk,
  input  logic                    hreset,
  input  logic                    hsel,
  input  logic [HADDR_WIDTH-1:0]  haddr,
  input  logic [1:0]              htrans,
  input  logic                    hwrite,
  input  logic [2:0]              hsize,
  input  logic [2:0]              hburst,
  input  logic [DATA_WIDTH-1:0]   hwdata,
  input  logic [DATA_WIDTH/8-1:0] hwstrb,
  input  logic                    hready,
  output logic [DATA_WIDTH-1:0]   hrdata,
  output logic                    hreadyout,
  output logic                    hresp
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int LSB   = $clog2(NB);
  localparam int IW    = $clog2(MEM_DEPTH);
  localparam int LSB_W = (LSB > 0) ? LSB : 1;
  localparam logic [2:0] MAX_SIZE = 3'(LSB);
  localparam logic [3:0] RD_LOAD  = (RD_WAIT > 0) ? 4'(RD_WAIT - 1) : '0;
  localparam logic [3:0] WR_LOAD  = (WR_WAIT > 0) ? 4'(WR_WAIT - 1) : '0;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                  dp_valid;
  logic                  dp_write;
  logic [IW-1:0]         dp_idx;
  logic [NB-1:0]         dp_mask;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] hrdata_q;

  logic                  accept;
  logic                  xfer_err;
  logic                  wr_commit;
  logic [IW-1:0]         acc_idx;
  logic [LSB_W-1:0]      byte_off;
  logic [NB-1:0]         lane_mask;
  logic [DATA_WIDTH-1:0] fwd_word;
  logic                  unused_bus;

  assign unused_bus = ^{hburst, htrans[0]};

  assign acc_idx  = haddr[LSB+IW-1:LSB];
  assign byte_off = (LSB > 0) ? haddr[LSB_W-1:0] : '0;
  assign accept   = hsel & hready & htrans[1] & (state == ST_IDLE);
  // A write's data phase always ends in ST_IDLE (straight after accept or after WAIT).
  assign wr_commit = dp_valid & dp_write & (state == ST_IDLE) & ~hreset;

  assign xfer_err = ((haddr >> (LSB + IW)) != '0)
                  || (hsize > MAX_SIZE)
                  || ((haddr[7:0] & ((8'd1 << hsize) - 8'd1)) != 8'd0);

  always_comb begin
    lane_mask = '0;
    for (int unsigned i = 0; i < NB; i++)
      lane_mask[i] = (i >= 32'(byte_off)) && (i < 32'(byte_off) + (32'd1 << hsize));
    if (USE_HWSTRB != 0)
      lane_mask = lane_mask & hwstrb;
  end

  // Read data seen at accept, merged with any write committing on the same edge.
  always_comb begin
    fwd_word = mem[acc_idx];
    if (wr_commit && (dp_idx == acc_idx))
      for (int unsigned b = 0; b < NB; b++)
        if (dp_mask[b])
          fwd_word[8*b +: 8] = hwdata[8*b +: 8];
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (xfer_err) begin
            state_nxt = ST_ERR1;
          end else if (hwrite && (WR_WAIT > 0)) begin
            state_nxt = ST_WAIT;
            cnt_nxt   = WR_LOAD;
          end else if (!hwrite && (RD_WAIT > 0)) begin
            state_nxt = ST_WAIT;
            cnt_nxt   = RD_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt == '0) state_nxt = ST_IDLE;
        else           cnt_nxt   = cnt - 4'd1;
      end
      ST_ERR1: state_nxt = ST_ERR2;
      ST_ERR2: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_idx   <= '0;
      dp_mask  <= '0;
      rd_word  <= '0;
      hrdata_q <= '0;
    end else begin
      if (accept) begin
        dp_valid <= ~xfer_err;
        dp_write <= hwrite;
        dp_idx   <= acc_idx;
        dp_mask  <= lane_mask;
        if (!hwrite && !xfer_err) begin
          rd_word <= fwd_word;
          if (RD_WAIT == 0) hrdata_q <= fwd_word;
        end
      end else if (state == ST_IDLE) begin
        dp_valid <= 1'b0;
      end
      // hrdata keeps the previous read until this read's final cycle.
      if ((state == ST_WAIT) && (cnt == '0) && !dp_write)
        hrdata_q <= rd_word;
    end
  end

  always_ff @(posedge hclk) begin
    if (wr_commit)
      for (int unsigned b = 0; b < NB; b++)
        if (dp_mask[b])
          mem[dp_idx][8*b +: 8] <= hwdata[8*b +: 8];
  end

  assign hrdata    = hrdata_q;
  assign hreadyout = (state == ST_IDLE) || (state == ST_ERR2);
  assign hresp     = (state == ST_ERR1) || (state == ST_ERR2);

endmodule

// File: doc/ahb_sram_ws.md
Name: ahb_sram_ws

Overview:
Parametrised AHB-Lite SRAM slave, next generation of the team's single-cycle SRAM slave. It adds the following over that block:
- configurable read/write wait states;
- hsize-based byte-lane writes, with optional hwstrb qualification;
- two-cycle ERROR response for out-of-range, misaligned or oversize transfers;
- read-after-write forwarding for back-to-back pipelined accesses.

It sits behind the AHB interconnect as a tightly coupled memory (ITCM/DTCM) target.

Parameters:
HADDR_WIDTH, 32, address bus width (10..64)
DATA_WIDTH, 32, data bus width (8..1024, power of 2)
MEM_DEPTH, 64, number of DATA_WIDTH words (power of 2)
RD_WAIT, 0, wait cycles inserted in every read data phase (0..15)
WR_WAIT, 0, wait cycles inserted in every write data phase (0..15)
USE_HWSTRB, 0, 1 = AND hsize lane mask with hwstrb

Ports:
hclk  in  1  clock
hreset  in  1  synchronous active-high reset
hsel  in  1  slave select
haddr  in  HADDR_WIDTH  address
htrans  in  2  transfer type
hwrite  in  1  1 = write
hsize  in  3  transfer size
hburst  in  3  burst type (ignored; each beat handled as a single transfer)
hwdata  in  DATA_WIDTH  write data
hwstrb  in  DATA_WIDTH/8  write strobes
hready  in  1  bus ready
hrdata  out  DATA_WIDTH  read data
hreadyout  out  1  slave ready
hresp  out  1  0 = OKAY, 1 = ERROR

Behaviour:
- Reset is synchronous on the hreset rising sample:
  - hreadyout=1, hresp=0, hrdata=0, state IDLE, wait counter 0, pending write discarded.
  - Memory array is not cleared and keeps its contents across reset.
- Derived values: NB=DATA_WIDTH/8; LSB=log2(NB); word index = haddr[LSB+log2(MEM_DEPTH)-1:LSB].
- Accept: an address phase is accepted on a rising edge when hsel & hready & htrans[1]. IDLE/BUSY or hsel=0 gives no access and zero-wait OKAY.
- Captured at accept: index, hwrite, lane mask. Lane mask = ((1<<(1<<hsize))-1) << haddr[LSB-1:0], ANDed with hwstrb when USE_HWSTRB=1.
- Error check at accept. Any of the following is an error:
  - haddr >= MEM_DEPTH*NB;
  - hsize > LSB;
  - haddr not aligned to 2^hsize.
- Error response:
  - Data-phase cycle 1: hreadyout=0, hresp=1. Cycle 2: hreadyout=1, hresp=1.
  - No array access. Any transfer presented during cycle 2 is not accepted (hready=1 only at the end of cycle 2 is legal per AHB; the master cancels).
- States:
  - IDLE: no data phase, or the final cycle of an OKAY data phase.
  - WAIT: counter counts down from RD_WAIT or WR_WAIT; hreadyout=0, hresp=0.
  - ERR1 and ERR2.
- Transitions:
  - IDLE -> WAIT on accept with an OK check and a nonzero wait count.
  - IDLE -> ERR1 on accept with a failed check.
  - WAIT -> IDLE when the counter reaches 0 (hreadyout=1 that cycle).
  - ERR1 -> ERR2 -> IDLE.
  - With zero wait, an accepted OK transfer stays IDLE and its data phase completes in 1 cycle.
- Read:
  - The array is read on the accept edge.
  - hrdata holds the full word (all lanes) from the completion cycle (hreadyout=1) until the next read completes.
  - Latency is 1+RD_WAIT cycles after accept.
- Write:
  - hwdata is sampled on the edge that ends the data phase (hreadyout=1).
  - Only lanes set in the mask are updated; other bytes are preserved.
- Forwarding: a read is accepted on the same edge that commits a write to the same index. The read data is then the merge of the old word with the written lanes. A read must never return stale data.
- Simultaneous accept and completion: the next address phase is accepted on the completion edge (pipelined). The new transfer's wait/error sequence starts the next cycle.
- Reset during WAIT or ERR: the transfer is aborted, no write is committed, and outputs take reset values the following cycle.

Test Plan:
1. Defaults: write 0xDEADBEEF to 0x10 (hsize=2), then read 0x10 back-to-back -> write completes with zero wait; read hrdata=0xDEADBEEF via forwarding, 1 cycle after accept.
2. Byte write: preload 0x11223344 at 0x20; write hsize=0 to 0x22 with hwdata=0x00AB0000 -> readback 0x11AB3344.
3. RD_WAIT=2, WR_WAIT=1: read 0x10 -> hreadyout low 2 cycles then high with data; write -> hreadyout low 1 cycle.
4. Errors (default sizes): read at 0x100, write hsize=2 at 0x02, and hsize=3 -> each gives ERR1 (hreadyout=0, hresp=1) then ERR2 (1,1); target words unchanged.
5. IDLE/BUSY htrans and hsel=0 with hready=1 -> hreadyout=1, hresp=0, no array change.
6. Assert hreset during a WR_WAIT=3 write -> next cycle hreadyout=1, hresp=0, hrdata=0; target word retains its old value.
